// File: rtl/rob_phase_pkg.sv
// Shared marker encodings, phase indices and event payload for the ROB phase tracker.
package rob_phase_pkg;

  localparam int unsigned NUM_PHASES = 7;
  localparam int unsigned NUM_CODES  = 14;
  localparam int unsigned EV_TS_W    = 64;
  localparam int unsigned EV_LANE_W  = 8;

  // Markers are "slti x0, x0, imm" with imm = code in bits [23:20].
  localparam logic [31:0] MARKER_MASK       = 32'hFF0F_FFFF;
  localparam logic [31:0] MARKER_BASE       = 32'h0000_2013;
  localparam logic [31:0] INFO_VCTM_START   = 32'h0000_2013;
  localparam logic [31:0] INFO_VCTM_END     = 32'h0010_2013;
  localparam logic [31:0] INFO_DELAY_START  = 32'h0020_2013;
  localparam logic [31:0] INFO_DELAY_END    = 32'h0030_2013;
  localparam logic [31:0] INFO_TEXE_START   = 32'h0040_2013;
  localparam logic [31:0] INFO_TEXE_END     = 32'h0050_2013;
  localparam logic [31:0] INFO_LEAK_START   = 32'h0060_2013;
  localparam logic [31:0] INFO_LEAK_END     = 32'h0070_2013;
  localparam logic [31:0] INFO_INIT_START   = 32'h0080_2013;
  localparam logic [31:0] INFO_INIT_END     = 32'h0090_2013;
  localparam logic [31:0] INFO_BIM_START    = 32'h00A0_2013;
  localparam logic [31:0] INFO_BIM_END      = 32'h00B0_2013;
  localparam logic [31:0] INFO_TRAIN_START  = 32'h00C0_2013;
  localparam logic [31:0] INFO_TRAIN_END    = 32'h00D0_2013;

  typedef enum logic [2:0] {
    PH_VCTM  = 3'd0,
    PH_DELAY = 3'd1,
    PH_TEXE  = 3'd2,
    PH_LEAK  = 3'd3,
    PH_INIT  = 3'd4,
    PH_BIM   = 3'd5,
    PH_TRAIN = 3'd6
  } phase_e;

  // Widest supported fields; the top truncates to its own TS_W / lane width.
  typedef struct packed {
    logic [EV_TS_W-1:0]   ts;
    logic [3:0]           code;
    logic [EV_LANE_W-1:0] lane;
  } rob_event_t;

  function automatic logic marker_match(input logic [31:0] inst);
    return ((inst & MARKER_MASK) == MARKER_BASE) && (inst[23:20] < 4'(NUM_CODES));
  endfunction

endpackage

// File: rtl/rob_event_fifo.sv
// Circular event buffer: up to NPUSH in-order pushes and one pop per cycle.
module rob_event_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned NPUSH = 2,
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
  localparam int unsigned NACC_W = $clog2(NPUSH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NPUSH-1:0]  push_valid_i,
  input  T                  push_data_i [NPUSH],
  input  logic              pop_i,
  output logic              valid_o,
  output T                  head_o,
  output logic [NACC_W-1:0] accepted_c_o
);

  T                  mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_q, wr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  space;
  logic [NACC_W-1:0] acc;
  logic [NPUSH-1:0]  take;
  logic [PTR_W-1:0]  slot [NPUSH];
  logic              pop;

  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_q];
  assign pop     = pop_i && valid_o;

  // Accept valid pushes oldest-first while space remains; a same-cycle pop frees one slot.
  always_comb begin
    space = CNT_W'(DEPTH) - count_q + CNT_W'(pop);
    acc   = '0;
    take  = '0;
    for (int i = 0; i < NPUSH; i++) begin
      slot[i] = wr_q + PTR_W'(acc);
      if (push_valid_i[i] && (CNT_W'(acc) < space)) begin
        take[i] = 1'b1;
        acc     = acc + NACC_W'(1);
      end
    end
  end

  assign accepted_c_o = acc;

  always_ff @(posedge clock) begin
    for (int i = 0; i < NPUSH; i++) begin
      if (take[i]) mem_q[slot[i]] <= push_data_i[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_q + PTR_W'(acc);
      rd_q    <= rd_q + PTR_W'(pop);
      count_q <= count_q + CNT_W'(acc) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/rob_phase_tracker.sv
// Decodes fuzzer marker retirements, tracks per-phase open state, cycle and taint
// counters, and queues timestamped marker events for the logger.
module rob_phase_tracker
  import rob_phase_pkg::*;
#(
  parameter int unsigned NCOMMIT   = 2,
  parameter int unsigned TAINT_W   = 32,
  parameter int unsigned ACC_W     = 48,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned TS_W      = 40,
  parameter int unsigned DEPTH     = 8,
  parameter logic [13:0] STOP_MASK = 14'h0082,
  localparam int unsigned LANE_W   = (NCOMMIT > 1) ? $clog2(NCOMMIT) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NCOMMIT-1:0]          commit_valid,
  input  logic [32*NCOMMIT-1:0]       commit_inst,
  input  logic [TAINT_W-1:0]          taint_sum,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [TS_W-1:0]             ev_ts,
  output logic [3:0]                  ev_code,
  output logic [LANE_W-1:0]           ev_lane,
  output logic [NUM_PHASES-1:0]       phase_open,
  output logic [NUM_PHASES*CNT_W-1:0] phase_cycles,
  output logic [NUM_PHASES*ACC_W-1:0] phase_taint,
  output logic [15:0]                 ev_dropped,
  output logic                        proto_err,
  output logic                        finish_req
);

  localparam int unsigned NACC_W = $clog2(NCOMMIT + 1);
  localparam int unsigned AW1    = ACC_W + 1;
  localparam logic [15:0] STOP_VEC = 16'(STOP_MASK);

  logic [TS_W-1:0]       ts_q;
  logic [NCOMMIT-1:0]    hit;
  logic [3:0]            code [NCOMMIT];
  rob_event_t            push_data [NCOMMIT];
  rob_event_t            head;
  logic [NACC_W-1:0]     n_hits, n_acc;
  logic                  stop_hit;
  logic [16:0]           drop_sum;
  logic [NUM_PHASES-1:0] open_d, err_vec;

  // Per-lane marker decode and event payload.
  always_comb begin
    n_hits   = '0;
    stop_hit = 1'b0;
    for (int l = 0; l < NCOMMIT; l++) begin
      hit[l]       = commit_valid[l] && marker_match(commit_inst[32*l +: 32]);
      code[l]      = commit_inst[32*l+20 +: 4];
      push_data[l] = '{ts: EV_TS_W'(ts_q), code: code[l], lane: EV_LANE_W'(l)};
      n_hits       = n_hits + NACC_W'(hit[l]);
      if (hit[l] && STOP_VEC[code[l]]) stop_hit = 1'b1;
    end
  end

  rob_event_fifo #(
    .T     (rob_event_t),
    .DEPTH (DEPTH),
    .NPUSH (NCOMMIT)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push_valid_i (hit),
    .push_data_i  (push_data),
    .pop_i        (ev_valid && ev_ready),
    .valid_o      (ev_valid),
    .head_o       (head),
    .accepted_c_o (n_acc)
  );

  assign ev_ts   = ev_valid ? TS_W'(head.ts)     : '0;
  assign ev_code = ev_valid ? head.code          : '0;
  assign ev_lane = ev_valid ? LANE_W'(head.lane) : '0;

  for (genvar p = 0; p < NUM_PHASES; p++) begin : g_phase
    logic             open_run, err_run;
    logic [CNT_W-1:0] cyc_q;
    logic [ACC_W-1:0] taint_q;
    logic [AW1-1:0]   taint_nxt;

    // Walk lanes oldest-first against the running open bit for this phase.
    always_comb begin
      open_run = phase_open[p];
      err_run  = 1'b0;
      for (int l = 0; l < NCOMMIT; l++) begin
        if (hit[l] && (phase_e'(code[l][3:1]) == phase_e'(p))) begin
          if (!code[l][0]) begin
            if (open_run) err_run = 1'b1;
            open_run = 1'b1;
          end else begin
            if (!open_run) err_run = 1'b1;
            open_run = 1'b0;
          end
        end
      end
    end

    assign open_d[p]  = open_run;
    assign err_vec[p] = err_run;
    assign taint_nxt  = {1'b0, taint_q} + AW1'(taint_sum);

    always_ff @(posedge clock) begin
      if (!reset) begin
        cyc_q   <= '0;
        taint_q <= '0;
      end else if (phase_open[p]) begin
        if (cyc_q != '1) cyc_q <= cyc_q + CNT_W'(1);
        taint_q <= taint_nxt[ACC_W] ? '1 : taint_nxt[ACC_W-1:0];
      end
    end

    assign phase_cycles[p*CNT_W +: CNT_W] = cyc_q;
    assign phase_taint[p*ACC_W +: ACC_W]  = taint_q;
  end

  assign drop_sum = 17'(ev_dropped) + 17'(n_hits - n_acc);

  always_ff @(posedge clock) begin
    if (!reset) begin
      ts_q       <= '0;
      phase_open <= '0;
      proto_err  <= 1'b0;
      finish_req <= 1'b0;
      ev_dropped <= '0;
    end else begin
      ts_q       <= ts_q + TS_W'(1);
      phase_open <= open_d;
      proto_err  <= proto_err | (|err_vec);
      finish_req <= finish_req | stop_hit;
      ev_dropped <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_rob_phase_tracker.sv
// Scoreboard bench for rob_phase_tracker (2 lanes, 33-bit taint accumulators).
module tb_rob_phase_tracker;
  import rob_phase_pkg::*;

  localparam int unsigned NC  = 2;
  localparam int unsigned TW  = 32;
  localparam int unsigned AW  = 33;
  localparam int unsigned CW  = 32;
  localparam int unsigned TSW = 40;
  localparam int unsigned DEP = 8;

  typedef struct {
    logic [TSW-1:0] ts;
    logic [3:0]     code;
    logic           lane;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NC-1:0]     commit_valid = '0;
  logic [32*NC-1:0]  commit_inst = '0;
  logic [TW-1:0]     taint_sum = '0;
  logic              ev_valid;
  logic              ev_ready = 1'b1;
  logic [TSW-1:0]    ev_ts;
  logic [3:0]        ev_code;
  logic [0:0]        ev_lane;
  logic [6:0]        phase_open;
  logic [7*CW-1:0]   phase_cycles;
  logic [7*AW-1:0]   phase_taint;
  logic [15:0]       ev_dropped;
  logic              proto_err;
  logic              finish_req;

  exp_t              sb[$];
  int                n_checks = 0;
  int                n_errors = 0;
  logic [TSW-1:0]    ts_model = '0;

  rob_phase_tracker #(
    .NCOMMIT   (NC),
    .TAINT_W   (TW),
    .ACC_W     (AW),
    .CNT_W     (CW),
    .TS_W      (TSW),
    .DEPTH     (DEP),
    .STOP_MASK (14'h0012)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .commit_valid (commit_valid),
    .commit_inst  (commit_inst),
    .taint_sum    (taint_sum),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_ts        (ev_ts),
    .ev_code      (ev_code),
    .ev_lane      (ev_lane),
    .phase_open   (phase_open),
    .phase_cycles (phase_cycles),
    .phase_taint  (phase_taint),
    .ev_dropped   (ev_dropped),
    .proto_err    (proto_err),
    .finish_req   (finish_req)
  );

  always #5 clock = ~clock;

  // Cycles since reset release: 0 in the first cycle with reset high.
  always @(posedge clock) ts_model <= reset ? ts_model + 40'd1 : 40'd0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic is_mk(input logic [31:0] inst);
    return (inst[19:0] == 20'h02013) && (inst[31:24] == 8'h00) && (inst[23:20] <= 4'd13);
  endfunction

  // Drive one commit cycle; expected events enter the scoreboard while the FIFO model has room.
  task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [TSW-1:0] exp_ts);
    logic [31:0] ins [2];
    ins[0] = i0;
    ins[1] = i1;
    commit_valid = v;
    commit_inst  = {i1, i0};
    for (int l = 0; l < 2; l++) begin
      if (v[l] && is_mk(ins[l]) && sb.size() < DEP)
        sb.push_back('{ts: exp_ts, code: ins[l][23:20], lane: 1'(l)});
    end
    step();
    commit_valid = '0;
    commit_inst  = '0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) step();
    check_eq("drain_empty", 64'(sb.size()), 64'd0);
    step();
    step();
    check_eq("drain_ev_valid", 64'(ev_valid), 64'd0);
  endtask

  task automatic wait_ts(input logic [TSW-1:0] target);
    for (int k = 0; k < 100 && ts_model != target; k++) step();
    check_eq("wait_ts", 64'(ts_model), 64'(target));
  endtask

  function automatic logic [CW-1:0] cyc(input int p);
    return phase_cycles[p*CW +: CW];
  endfunction

  function automatic logic [AW-1:0] tnt(input int p);
    return phase_taint[p*AW +: AW];
  endfunction

  // Pop-side compare: the head leaves at the next edge when valid && ready.
  always @(negedge clock) begin
    if (reset && ev_valid && ev_ready) begin
      check_eq("ev_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check_eq("ev_ts", 64'(ev_ts), 64'(e.ts));
        check_eq("ev_code", 64'(ev_code), 64'(e.code));
        check_eq("ev_lane", 64'(ev_lane), 64'(e.lane));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TSW-1:0] head_ts;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    check_eq("rst_ev_valid", 64'(ev_valid), 64'd0);
    check_eq("rst_phase_open", 64'(phase_open), 64'd0);
    check_eq("rst_dropped", 64'(ev_dropped), 64'd0);
    check_eq("rst_proto", 64'(proto_err), 64'd0);
    check_eq("rst_finish", 64'(finish_req), 64'd0);

    // INIT open from cycle 10 to cycle 15 with taint 3.
    taint_sum = 32'd3;
    wait_ts(40'd10);
    drive(2'b01, INFO_INIT_START, 32'h0, 40'd10);
    check_eq("init_open", 64'(phase_open), 64'h10);
    check_eq("init_cyc_first", 64'(cyc(4)), 64'd0);
    wait_ts(40'd15);
    drive(2'b01, INFO_INIT_END, 32'h0, 40'd15);
    taint_sum = '0;
    check_eq("init_closed", 64'(phase_open), 64'd0);
    check_eq("init_cycles", 64'(cyc(4)), 64'd5);
    check_eq("init_taint", 64'(tnt(4)), 64'd15);
    check_eq("init_proto", 64'(proto_err), 64'd0);
    drain();

    // Same-cycle TEXE start/end; TEXE_START is a stop marker here.
    check_eq("finish_before", 64'(finish_req), 64'd0);
    drive(2'b11, INFO_TEXE_START, INFO_TEXE_END, ts_model);
    check_eq("texe_open", 64'(phase_open[2]), 64'd0);
    check_eq("texe_cycles", 64'(cyc(2)), 64'd0);
    check_eq("texe_finish", 64'(finish_req), 64'd1);
    check_eq("texe_proto", 64'(proto_err), 64'd0);
    drain();

    // Back-pressure: 10 markers into 8 entries; the 9th and 10th are dropped.
    ev_ready = 1'b0;
    drive(2'b01, INFO_BIM_START, 32'h0, ts_model);
    drive(2'b11, INFO_BIM_END, INFO_TRAIN_START, ts_model);
    drive(2'b11, INFO_TRAIN_END, INFO_BIM_START, ts_model);
    drive(2'b11, INFO_BIM_END, INFO_TRAIN_START, ts_model);
    drive(2'b11, INFO_TRAIN_END, INFO_BIM_START, ts_model);
    drive(2'b01, INFO_BIM_END, 32'h0, ts_model);
    step();
    head_ts = sb[0].ts;
    check_eq("full_queued", 64'(sb.size()), 64'd8);
    check_eq("full_dropped", 64'(ev_dropped), 64'd2);
    check_eq("full_valid", 64'(ev_valid), 64'd1);
    check_eq("full_head_code", 64'(ev_code), 64'd10);
    check_eq("full_head_ts", 64'(ev_ts), 64'(head_ts));
    repeat (3) step();
    check_eq("stall_head_code", 64'(ev_code), 64'd10);
    check_eq("stall_head_lane", 64'(ev_lane), 64'd0);
    check_eq("stall_head_ts", 64'(ev_ts), 64'(head_ts));
    check_eq("full_phases", 64'(phase_open), 64'd0);
    check_eq("full_proto", 64'(proto_err), 64'd0);
    ev_ready = 1'b1;
    drain();

    // END of a closed phase.
    drive(2'b01, INFO_DELAY_END, 32'h0, ts_model);
    check_eq("proto_set", 64'(proto_err), 64'd1);
    check_eq("proto_open", 64'(phase_open), 64'd0);
    drain();
    check_eq("proto_sticky", 64'(proto_err), 64'd1);

    // Taint saturation over three open LEAK cycles.
    taint_sum = 32'hFFFF_FFFF;
    drive(2'b01, INFO_LEAK_START, 32'h0, ts_model);
    check_eq("sat_t0", 64'(tnt(3)), 64'd0);
    step();
    check_eq("sat_t1", 64'(tnt(3)), 64'hFFFF_FFFF);
    step();
    check_eq("sat_t2", 64'(tnt(3)), 64'h1_FFFF_FFFE);
    drive(2'b01, INFO_LEAK_END, 32'h0, ts_model);
    step();
    taint_sum = '0;
    check_eq("sat_taint", 64'(tnt(3)), 64'h1_FFFF_FFFF);
    check_eq("sat_cycles", 64'(cyc(3)), 64'd3);
    check_eq("sat_closed", 64'(phase_open[3]), 64'd0);
    drain();

    // Reset mid-phase with three queued events.
    ev_ready = 1'b0;
    taint_sum = 32'd7;
    drive(2'b11, INFO_VCTM_START, INFO_DELAY_START, ts_model);
    drive(2'b01, INFO_BIM_START, 32'h0, ts_model);
    step();
    check_eq("pre_rst_valid", 64'(ev_valid), 64'd1);
    check_eq("pre_rst_open", 64'(phase_open), 64'h23);
    reset = 1'b0;
    step();
    step();
    sb.delete();
    ev_ready = 1'b1;
    taint_sum = '0;
    reset = 1'b1;
    check_eq("mid_rst_valid", 64'(ev_valid), 64'd0);
    check_eq("mid_rst_open", 64'(phase_open), 64'd0);
    check_eq("mid_rst_dropped", 64'(ev_dropped), 64'd0);
    check_eq("mid_rst_proto", 64'(proto_err), 64'd0);
    check_eq("mid_rst_finish", 64'(finish_req), 64'd0);
    for (int p = 0; p < 7; p++) begin
      check_eq($sformatf("mid_rst_cyc%0d", p), 64'(cyc(p)), 64'd0);
      check_eq($sformatf("mid_rst_tnt%0d", p), 64'(tnt(p)), 64'd0);
    end
    drive(2'b01, INFO_VCTM_START, 32'h0, 40'd0);
    check_eq("post_rst_open", 64'(phase_open), 64'h01);
    drain();
    check_eq("post_rst_finish", 64'(finish_req), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
